// File: rtl/dmem_responder.sv
// Memory-side responder for the core data-memory port: word store, fixed-latency response, network preload port.
// from_core_i = {write_data[31:0], valid, wen, byte_not_word, yumi}; to_core_o = {read_data[31:0], valid, yumi}.
module dmem_responder #(
  parameter int ADDR_WIDTH_P = 12,
  parameter int LATENCY_P    = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [35:0]             from_core_i,
  input  logic [ADDR_WIDTH_P-1:0] addr_i,
  output logic [33:0]             to_core_o,
  input  logic                    net_wen_i,
  input  logic [ADDR_WIDTH_P-3:0] net_addr_i,
  input  logic [31:0]             net_data_i,
  output logic                    err_o
);

  localparam int DEPTH = 1 << (ADDR_WIDTH_P - 2);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY_P - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] r_mem [DEPTH];
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0]             w_wdata;
  logic                    w_req_valid;
  logic                    w_wen;
  logic                    w_bnw;
  logic                    w_core_yumi;
  logic [ADDR_WIDTH_P-3:0] w_idx;
  logic [1:0]              w_lane;
  logic [31:0]             w_word;
  logic [7:0]              w_lane_byte;
  logic                    w_misalign;
  logic                    w_accept;
  logic                    w_valid;
  logic [31:0]             w_cap;
  logic [31:0]             w_merged;
  logic                    w_mem_we;
  logic [ADDR_WIDTH_P-3:0] w_mem_idx;
  logic [31:0]             w_mem_wdata;

  assign w_wdata     = from_core_i[35:4];
  assign w_req_valid = from_core_i[3];
  assign w_wen       = from_core_i[2];
  assign w_bnw       = from_core_i[1];
  assign w_core_yumi = from_core_i[0];

  assign w_idx       = addr_i[ADDR_WIDTH_P-1:2];
  assign w_lane      = addr_i[1:0];
  assign w_word      = r_mem[w_idx];
  assign w_lane_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_misalign  = !w_bnw && (w_lane != 2'b00);

  // Network writes win the store port; the core request simply stays pending.
  assign w_accept = (r_state == S_IDLE) && w_req_valid && !net_wen_i && n_reset;
  assign w_valid  = (r_state == S_RESP);

  // Writes and misaligned accesses respond with zero data.
  assign w_cap = (w_wen || w_misalign) ? 32'b0
               : (w_bnw ? {24'b0, w_lane_byte} : w_word);

  always_comb begin
    w_merged = w_word;
    w_merged[{w_lane, 3'b000} +: 8] = w_wdata[7:0];
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = net_addr_i;
    w_mem_wdata = net_data_i;
    if (net_wen_i) begin
      w_mem_we = 1'b1;
    end else if (w_accept && w_wen && !w_misalign) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = w_idx;
      w_mem_wdata = w_bnw ? w_merged : w_wdata;
    end
  end

  // Store contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept && w_misalign) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rdata <= w_cap;
            if (LATENCY_P == 1) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_core_yumi) begin
            r_state <= S_IDLE;
            r_rdata <= 32'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign to_core_o = {(w_valid ? r_rdata : 32'b0), w_valid, w_accept};
  assign err_o     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 2 and 1) driven in lockstep against a transaction-level model.
module tb_dmem_responder;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_reset;
  logic          req_valid, req_wen, req_bnw, core_yumi;
  logic [31:0]   req_wdata;
  logic [AW-1:0] req_addr;
  logic          net_wen;
  logic [AW-3:0] net_addr;
  logic [31:0]   net_data;
  logic [35:0]   from_core;
  logic [33:0]   to_core_l2, to_core_l1;
  logic          err_l2, err_l1;

  assign from_core = {req_wdata, req_valid, req_wen, req_bnw, core_yumi};

  dmem_responder #(.ADDR_WIDTH_P(AW), .LATENCY_P(2)) u_dut_l2 (
    .clk(clk), .n_reset(n_reset), .from_core_i(from_core), .addr_i(req_addr),
    .to_core_o(to_core_l2), .net_wen_i(net_wen), .net_addr_i(net_addr),
    .net_data_i(net_data), .err_o(err_l2)
  );

  dmem_responder #(.ADDR_WIDTH_P(AW), .LATENCY_P(1)) u_dut_l1 (
    .clk(clk), .n_reset(n_reset), .from_core_i(from_core), .addr_i(req_addr),
    .to_core_o(to_core_l1), .net_wen_i(net_wen), .net_addr_i(net_addr),
    .net_data_i(net_data), .err_o(err_l1)
  );

  // Reference model: per instance a word array and one outstanding response record.
  int          lat_m [2] = '{2, 1};
  logic [31:0] mem_m [2][16];
  bit          busy_m [2];
  int          ready_m [2];
  logic [31:0] rdat_m [2];
  bit          err_m [2];
  int          cyc = 0;

  logic        s_yumi [2];
  logic        s_valid [2];
  logic [31:0] s_rdata [2];
  logic        s_err [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_yumi(int k);
    return n_reset && !busy_m[k] && req_valid && !net_wen;
  endfunction

  function automatic bit exp_valid(int k);
    return busy_m[k] && (cyc >= ready_m[k]);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
    if (!n_reset) begin
      for (int k = 0; k < 2; k++) begin
        busy_m[k] = 1'b0;
        err_m[k]  = 1'b0;
      end
    end
    s_yumi[0] = to_core_l2[0]; s_valid[0] = to_core_l2[1]; s_rdata[0] = to_core_l2[33:2]; s_err[0] = err_l2;
    s_yumi[1] = to_core_l1[0]; s_valid[1] = to_core_l1[1]; s_rdata[1] = to_core_l1[33:2]; s_err[1] = err_l1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("yumi%0d", k), 32'(s_yumi[k]), 32'(exp_yumi(k)));
      check_val($sformatf("valid%0d", k), 32'(s_valid[k]), 32'(exp_valid(k)));
      check_val($sformatf("rdata%0d", k), s_rdata[k], exp_valid(k) ? rdat_m[k] : 32'b0);
      check_val($sformatf("err%0d", k), 32'(s_err[k]), 32'(err_m[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit acc;
      bit vld;
      acc = exp_yumi(k);
      vld = exp_valid(k);
      if (net_wen) mem_m[k][net_addr[3:0]] = net_data;
      if (acc) begin
        int idx;
        int ln;
        idx = int'(req_addr[5:2]);
        ln  = int'(req_addr[1:0]);
        busy_m[k]  = 1'b1;
        ready_m[k] = cyc + lat_m[k];
        if (!req_bnw && ln != 0) begin
          err_m[k]  = 1'b1;
          rdat_m[k] = 32'b0;
        end else if (req_wen) begin
          if (req_bnw) mem_m[k][idx][ln*8 +: 8] = req_wdata[7:0];
          else         mem_m[k][idx] = req_wdata;
          rdat_m[k] = 32'b0;
        end else if (req_bnw) begin
          rdat_m[k] = {24'b0, mem_m[k][idx][ln*8 +: 8]};
        end else begin
          rdat_m[k] = mem_m[k][idx];
        end
      end else if (vld && core_yumi) begin
        busy_m[k] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic collect(input int hold, input bit keep, output logic [31:0] rd,
                         output int lat0, output int lat1);
    int n;
    if (!keep) req_valid = 1'b0;
    core_yumi = 1'b0;
    net_wen   = 1'b0;
    n = 0; lat1 = 0;
    do begin
      step();
      n++;
      if (s_valid[1] === 1'b1 && lat1 == 0) lat1 = n;
    end while (s_valid[0] !== 1'b1 && n < 20);
    lat0 = (s_valid[0] === 1'b1) ? n : -1;
    rd = s_rdata[0];
    for (int h = 0; h < hold; h++) begin
      step();
      check_val("hold_valid", 32'(s_valid[0]), 32'd1);
      check_val("hold_data", s_rdata[0], rd);
    end
    core_yumi = 1'b1;
    step();
    core_yumi = 1'b0;
  endtask

  task automatic txn(input logic [AW-1:0] a, input logic w, input logic b, input logic [31:0] d,
                     input int hold, output logic [31:0] rd, output int lat0, output int lat1);
    req_addr = a; req_wen = w; req_bnw = b; req_wdata = d; req_valid = 1'b1;
    core_yumi = 1'b0; net_wen = 1'b0;
    step();
    check_val("txn_accept", 32'(s_yumi[0]), 32'd1);
    collect(hold, 1'b0, rd, lat0, lat1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int l0, l1;
    n_reset = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_bnw = 1'b0; core_yumi = 1'b0;
    req_wdata = 32'b0; req_addr = '0;
    net_wen = 1'b0; net_addr = '0; net_data = 32'b0;
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 1'b0; ready_m[k] = 0; rdat_m[k] = 32'b0; err_m[k] = 1'b0;
    end

    step();
    step();
    n_reset = 1'b1;

    // Preload every word used below; word 5 gets the known pattern.
    for (int i = 0; i < 16; i++) begin
      net_wen  = 1'b1;
      net_addr = 10'(i);
      net_data = (i == 5) ? 32'hDEADBEEF : $urandom;
      step();
    end
    net_wen = 1'b0;

    txn(12'h014, 1'b0, 1'b0, 32'b0, 0, rd, l0, l1);
    check_val("rd_deadbeef", rd, 32'hDEADBEEF);
    check_val("lat_l2", 32'(l0), 32'd2);
    check_val("lat_l1", 32'(l1), 32'd1);
    step();
    check_val("valid_after_consume", 32'(s_valid[0]), 32'd0);

    txn(12'h016, 1'b1, 1'b1, 32'h000000A5, 0, rd, l0, l1);
    check_val("wr_resp_zero", rd, 32'h0);
    txn(12'h014, 1'b0, 1'b0, 32'b0, 0, rd, l0, l1);
    check_val("rd_after_bytewr", rd, 32'hDEA5BEEF);
    txn(12'h017, 1'b0, 1'b1, 32'b0, 0, rd, l0, l1);
    check_val("lbu", rd, 32'h000000DE);

    // Backpressure with a second request held pending across the consume.
    req_addr = 12'h014; req_wen = 1'b0; req_bnw = 1'b0; req_valid = 1'b1;
    step();
    check_val("bp_accept", 32'(s_yumi[0]), 32'd1);
    collect(5, 1'b1, rd, l0, l1);
    check_val("bp_data", rd, 32'hDEA5BEEF);
    check_val("bp_no_overlap", 32'(s_yumi[0]), 32'd0);
    step();
    check_val("bp_second_accept", 32'(s_yumi[0]), 32'd1);
    check_val("bp_valid_low", 32'(s_valid[0]), 32'd0);
    collect(0, 1'b0, rd, l0, l1);
    check_val("bp_second_data", rd, 32'hDEA5BEEF);

    // Network write collides with a core request, then overwrites during WAIT.
    req_addr = 12'h018; req_wen = 1'b0; req_bnw = 1'b0; req_valid = 1'b1;
    net_wen = 1'b1; net_addr = 10'd6; net_data = 32'h12345678;
    step();
    check_val("net_prio_yumi", 32'(s_yumi[0]), 32'd0);
    net_wen = 1'b0;
    step();
    check_val("net_then_accept", 32'(s_yumi[0]), 32'd1);
    req_valid = 1'b0;
    net_wen = 1'b1; net_data = 32'hCAFEF00D;
    step();
    collect(0, 1'b0, rd, l0, l1);
    check_val("pre_write_data", rd, 32'h12345678);
    txn(12'h018, 1'b0, 1'b0, 32'b0, 0, rd, l0, l1);
    check_val("post_write_data", rd, 32'hCAFEF00D);

    txn(12'h013, 1'b0, 1'b0, 32'b0, 0, rd, l0, l1);
    check_val("misalign_data", rd, 32'h0);
    check_val("misalign_err", 32'(s_err[0]), 32'd1);
    txn(12'h014, 1'b0, 1'b0, 32'b0, 0, rd, l0, l1);
    check_val("err_sticky", 32'(s_err[0]), 32'd1);
    check_val("good_after_err", rd, 32'hDEA5BEEF);

    // Asynchronous reset while the write response is in flight.
    req_addr = 12'h01C; req_wen = 1'b1; req_bnw = 1'b0; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_reset = 1'b0;
    step();
    check_val("rst_valid_l2", 32'(s_valid[0]), 32'd0);
    check_val("rst_valid_l1", 32'(s_valid[1]), 32'd0);
    check_val("rst_err", 32'(s_err[0]), 32'd0);
    n_reset = 1'b1;
    txn(12'h01C, 1'b0, 1'b0, 32'b0, 0, rd, l0, l1);
    check_val("write_survives_rst", rd, 32'h0BADF00D);
    check_val("lat_l2_again", 32'(l0), 32'd2);
    check_val("lat_l1_again", 32'(l1), 32'd1);

    // Randomized traffic; each instance is tracked independently by the model.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] ln;
      req_valid = ($urandom_range(0, 9) < 7);
      req_wen   = ($urandom_range(0, 9) < 4);
      req_bnw   = $urandom_range(0, 1) == 1;
      ln        = (req_bnw || $urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_addr  = {6'b0, 4'($urandom_range(0, 15)), ln};
      req_wdata = $urandom;
      net_wen   = ($urandom_range(0, 7) == 0);
      net_addr  = 10'($urandom_range(0, 15));
      net_data  = $urandom;
      core_yumi = $urandom_range(0, 1) == 1;
      n_reset   = ($urandom_range(0, 199) != 0);
      step();
    end
    n_reset = 1'b1;
    req_valid = 1'b0; net_wen = 1'b0; core_yumi = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
